dmac_chan_sched: RTL and testbench
==================================

# dmac_chan_sched

Channel scheduler for the DMA controller. It takes the peripheral request lines (`DmacReq`) and picks one channel at a time, using either fixed priority or round-robin. It runs the `Bus_Req`/`Bus_Grant` handshake with the system arbiter, sends the `ReqAck` pulse back to the winning peripheral, and enables exactly one channel datapath until that channel reports done or error. It also holds the per-channel completion status that drives `Interrupt`.

## Interface
- `NUM_CH`, default 2: number of DMA channels. Legal range 2–8.
- `RR_EN`, default 0: arbitration mode.
  - 0: fixed priority, highest index wins.
  - 1: round-robin.
- `CH_W`, default `$clog2(NUM_CH)`: channel index width. Derived; do not override.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `DmacReq` in `NUM_CH`: peripheral transfer requests, level.
- `Bus_Grant` in 1: bus granted to the DMAC by the system arbiter.
- `Ch_Done` in 1: single-cycle pulse; the active channel has finished its transfer count.
- `Ch_Err` in 1: single-cycle pulse; the active channel saw an ERROR `HResp`.
- `Irq_Clr` in `NUM_CH`: write-1-to-clear for the matching bits of `Irq_Src`.
- `ReqAck` out `NUM_CH`: one-hot, one-cycle acknowledge to the winning peripheral.
- `Bus_Req` out 1: bus request to the system arbiter.
- `Ch_En` out `NUM_CH`: one-hot enable for the active channel datapath.
- `Ch_Hold` out 1: grant was lost mid-transfer; the channel must stall with `HTRANS=IDLE`.
- `Active_Ch` out `CH_W`: index of the active or pending channel.
- `Irq_Src` out `NUM_CH`: sticky per-channel completion flags.
- `Err_Src` out `NUM_CH`: sticky per-channel error flags.
- `Interrupt` out 1: `|Irq_Src`.

## Operation
- States: IDLE, REQ_BUS, ACK, XFER, DONE. Encoding is free.
- **IDLE**
  - If `|DmacReq`, arbitrate, latch the winner into `Active_Ch`, then go to REQ_BUS.
  - Fixed mode: the highest set index wins.
  - Round-robin mode: search upward from pointer `rr_ptr`, wrapping to 0. The first set bit wins.
- **REQ_BUS**
  - `Bus_Req=1`.
  - If `DmacReq[Active_Ch]` drops before grant: abandon, go to IDLE, `Bus_Req` low the next cycle, no ack.
  - Else if `Bus_Grant`: go to ACK.
- **ACK**
  - `ReqAck[Active_Ch]=1` for exactly this one cycle.
  - `Ch_En[Active_Ch]=1`, `Bus_Req=1`.
  - Go to XFER.
- **XFER**
  - `Ch_En` and `Bus_Req` are held.
  - `DmacReq` changes are ignored; there is no preemption.
  - `Ch_Err` → DONE with error.
  - `Ch_Done` (without `Ch_Err`) → DONE.
  - Simultaneous `Ch_Done` and `Ch_Err`: treated as error.
- **DONE**
  - `Ch_En=0`, `Bus_Req=0`.
  - `Irq_Src[Active_Ch]` was set on entry; on error, `Err_Src[Active_Ch]` was also set on entry.
  - `rr_ptr` ← `Active_Ch+1`, wrapping at `NUM_CH` (not a power-of-2 wrap).
  - Go to IDLE.
- `Ch_Hold = (state==XFER) & ~Bus_Grant`. This is the only combinational output; all other outputs are registered.
- `Ch_Done`/`Ch_Err` outside XFER are ignored.
- `Irq_Clr`:
  - Clears the matching `Irq_Src` and `Err_Src` bits.
  - A set and a clear on the same bit in the same cycle: set wins.
  - Flags do not block arbitration; a new request is served while `Interrupt` is high.

## Timing
- Reset:
  - State IDLE, `rr_ptr=0`, `Active_Ch=0`.
  - All outputs 0: `ReqAck`, `Bus_Req`, `Ch_En`, `Ch_Hold`, `Irq_Src`, `Err_Src`, `Interrupt`.
  - Reset mid-transfer drops `Ch_En` and `Bus_Req` on that same edge; no status is recorded.
- Request to bus request: `DmacReq` sampled at edge k → `Bus_Req` high after edge k.
- Grant to ack: `Bus_Grant` sampled at edge k+1 → `ReqAck` and `Ch_En` high after edge k+1. With grant already high, minimum request-to-ack is 2 cycles.
- `ReqAck` is high for exactly one cycle. `Ch_En` rises in the same cycle as `ReqAck`.
- Completion: `Ch_Done` sampled at edge m →
  - `Ch_En` and `Bus_Req` low after edge m;
  - `Irq_Src` bit set after edge m;
  - `Interrupt` high after edge m;
  - IDLE after edge m+1.
- Back-to-back: next `Bus_Req` rises no earlier than 2 cycles after `Ch_Done` is sampled. This includes a 1-cycle bus release.
- Grant loss in XFER: `Ch_Hold` follows `~Bus_Grant` in the same cycle. `Bus_Req` stays high and no state change occurs.

## Test plan
- **Single request, grant already high.** Hold `DmacReq=01` (`NUM_CH=2`). Expect `Bus_Req` at +1, `ReqAck=01` and `Ch_En=01` at +2. Pulse `Ch_Done` at +10 → `Ch_En=00`, `Irq_Src=01`, `Interrupt=1` at +11. `Irq_Clr=01` → `Interrupt=0` next cycle.
- **Fixed priority.** `RR_EN=0`, `DmacReq=11`: ch1 acked first. After its `Ch_Done`, ch0 is acked; `Irq_Src` ends at `11`.
- **Round-robin.** `RR_EN=1`, `NUM_CH=4`, `DmacReq=1111` held with acks ignored. Service order must be 0,1,2,3,0. Verify `rr_ptr` wraps from 3 to 0.
- **Grant handling.**
  - Grant withheld 5 cycles: `Bus_Req` stays high with no ack.
  - Drop `DmacReq` before grant: return to IDLE, `Bus_Req` low, no `ReqAck`.
  - Drop `Bus_Grant` 3 cycles mid-XFER: `Ch_Hold=1` for exactly those cycles, `Ch_En` unchanged.
- **Error path.** `Ch_Err` and `Ch_Done` in the same cycle on ch1 → `Err_Src=10`, `Irq_Src=10`. Same-cycle `Irq_Clr=10` with the set: bit remains set.
- **Reset mid-XFER.** Assert `rst` one cycle → all outputs 0 on that edge. Re-request → normal 2-cycle ack latency, starting from `rr_ptr=0`.

Source files
------------

// File: rtl/dmac_chan_sched.sv
// dmac_chan_sched: DMA channel scheduler.
//   Picks one requesting channel (fixed priority or round-robin) and runs the
//   Bus_Req/Bus_Grant handshake with the system arbiter. It acks the winning
//   peripheral and enables that channel's datapath until it reports done or
//   error. It also keeps the sticky per-channel completion and error flags.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   DmacReq       : per-channel transfer requests (level)
//   Bus_Grant     : bus granted by system arbiter
//   Ch_Done/Ch_Err: one-cycle completion/error pulses from the active channel
//   Irq_Clr       : write-1-to-clear for Irq_Src/Err_Src
//   ReqAck        : one-hot, one-cycle ack to the winning peripheral
//   Bus_Req       : bus request to the system arbiter
//   Ch_En         : one-hot datapath enable
//   Ch_Hold       : grant lost mid-transfer (combinational)
//   Active_Ch     : active/pending channel index
//   Irq_Src/Err_Src: sticky completion/error flags; Interrupt = |Irq_Src

// Per-channel sticky status. When a set and a clear hit the same bit in one
// cycle, the set wins.
module dmac_chan_flag (
  input  logic clk,
  input  logic rst,
  input  logic set_irq,
  input  logic set_err,
  input  logic clr,
  output logic irq,
  output logic err,
  output logic irq_nxt
);
  assign irq_nxt = set_irq | (irq & ~clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
      err <= 1'b0;
    end else begin
      irq <= irq_nxt;
      err <= set_err | (err & ~clr);
    end
  end
endmodule

module dmac_chan_sched #(
  parameter int NUM_CH = 2,
  parameter int RR_EN  = 0,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] DmacReq,
  input  logic              Bus_Grant,
  input  logic              Ch_Done,
  input  logic              Ch_Err,
  input  logic [NUM_CH-1:0] Irq_Clr,
  output logic [NUM_CH-1:0] ReqAck,
  output logic              Bus_Req,
  output logic [NUM_CH-1:0] Ch_En,
  output logic              Ch_Hold,
  output logic [CH_W-1:0]   Active_Ch,
  output logic [NUM_CH-1:0] Irq_Src,
  output logic [NUM_CH-1:0] Err_Src,
  output logic              Interrupt
);
  typedef enum logic [2:0] {S_IDLE, S_REQ_BUS, S_ACK, S_XFER, S_DONE} state_t;

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   win;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] irq_nxt;
  logic              fin;

  // Winner select. Round-robin searches upward from rr_ptr with a modulo
  // NUM_CH wrap (NUM_CH need not be a power of 2); fixed mode lets the
  // highest set index overwrite lower ones.
  always_comb begin
    int j;
    logic found;
    win   = '0;
    found = 1'b0;
    j     = 0;
    if (RR_EN != 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        j = int'(rr_ptr) + i;
        if (j >= NUM_CH) j = j - NUM_CH;
        if (!found && DmacReq[CH_W'(j)]) begin
          found = 1'b1;
          win   = CH_W'(j);
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (DmacReq[i]) win = CH_W'(i);
    end
  end

  always_comb begin
    sel            = '0;
    sel[Active_Ch] = 1'b1;
  end

  // Done/Err only count while a transfer is running; an error takes priority.
  assign fin     = (state == S_XFER) && (Ch_Done || Ch_Err);
  assign Ch_Hold = (state == S_XFER) && !Bus_Grant;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flag
    dmac_chan_flag u_flag (
      .clk     (clk),
      .rst     (rst),
      .set_irq (fin && sel[g]),
      .set_err (fin && Ch_Err && sel[g]),
      .clr     (Irq_Clr[g]),
      .irq     (Irq_Src[g]),
      .err     (Err_Src[g]),
      .irq_nxt (irq_nxt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) Interrupt <= 1'b0;
    else     Interrupt <= |irq_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      Active_Ch <= '0;
      ReqAck    <= '0;
      Bus_Req   <= 1'b0;
      Ch_En     <= '0;
    end else begin
      ReqAck <= '0;
      case (state)
        S_IDLE: begin
          if (|DmacReq) begin
            Active_Ch <= win;
            Bus_Req   <= 1'b1;
            state     <= S_REQ_BUS;
          end
        end
        S_REQ_BUS: begin
          // A requester that gives up before grant is dropped without an ack.
          if (!DmacReq[Active_Ch]) begin
            Bus_Req <= 1'b0;
            state   <= S_IDLE;
          end else if (Bus_Grant) begin
            ReqAck <= sel;
            Ch_En  <= sel;
            state  <= S_ACK;
          end
        end
        S_ACK: state <= S_XFER;
        S_XFER: begin
          // No preemption: DmacReq is ignored; grant loss only raises Ch_Hold.
          if (fin) begin
            Ch_En   <= '0;
            Bus_Req <= 1'b0;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (int'(Active_Ch) == NUM_CH - 1) rr_ptr <= '0;
          else                               rr_ptr <= Active_Ch + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmac_chan_sched.sv
module tb_dmac_chan_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-priority instance, NUM_CH=2
  logic       rst_f, grant_f, done_f, err_f, req_f_bus, hold_f, act_f, intr_f;
  logic [1:0] req_f, clr_f, ack_f, en_f, irq_f, errs_f;
  // Round-robin instance, NUM_CH=4
  logic       rst_r, grant_r, done_r, err_r, req_r_bus, hold_r, intr_r;
  logic [1:0] act_r;
  logic [3:0] req_r, clr_r, ack_r, en_r, irq_r, errs_r;

  int n_chk = 0;
  int n_err = 0;

  dmac_chan_sched #(.NUM_CH(2), .RR_EN(0)) u_fix (
    .clk(clk), .rst(rst_f), .DmacReq(req_f), .Bus_Grant(grant_f),
    .Ch_Done(done_f), .Ch_Err(err_f), .Irq_Clr(clr_f), .ReqAck(ack_f),
    .Bus_Req(req_f_bus), .Ch_En(en_f), .Ch_Hold(hold_f), .Active_Ch(act_f),
    .Irq_Src(irq_f), .Err_Src(errs_f), .Interrupt(intr_f)
  );

  dmac_chan_sched #(.NUM_CH(4), .RR_EN(1)) u_rr (
    .clk(clk), .rst(rst_r), .DmacReq(req_r), .Bus_Grant(grant_r),
    .Ch_Done(done_r), .Ch_Err(err_r), .Irq_Clr(clr_r), .ReqAck(ack_r),
    .Bus_Req(req_r_bus), .Ch_En(en_r), .Ch_Hold(hold_r), .Active_Ch(act_r),
    .Irq_Src(irq_r), .Err_Src(errs_r), .Interrupt(intr_r)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for any ack; a timeout returns 0 and fails the caller's check.
  task automatic wait_ack(input bit rr, output logic [3:0] ack);
    ack = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ack = rr ? ack_r : {2'b00, ack_f};
      if (ack != 0) break;
    end
  endtask

  task automatic pulse_done_f(input logic [1:0] req_next, input logic e, input logic [1:0] clr);
    done_f = 1'b1; err_f = e; req_f = req_next; clr_f = clr;
    tick();
    done_f = 1'b0; err_f = 1'b0; clr_f = 2'b00;
  endtask

  logic [3:0] ack;
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_f = 1; grant_f = 1; done_f = 0; err_f = 0; req_f = 0; clr_f = 0;
    rst_r = 1; grant_r = 1; done_r = 0; err_r = 0; req_r = 0; clr_r = 0;
    tick(); tick();
    chk("rst_bus_req", req_f_bus, 0);
    chk("rst_ch_en",   en_f, 0);
    chk("rst_ack",     ack_f, 0);
    chk("rst_irq",     {irq_f, errs_f, intr_f}, 0);
    chk("rst_act",     act_f, 0);
    rst_f = 0; rst_r = 0;
    tick();

    // Single request, grant already high
    req_f = 2'b01;
    tick();
    chk("single_bus_req_+1", req_f_bus, 1);
    chk("single_no_ack_+1",  ack_f, 0);
    tick();
    chk("single_ack_+2", ack_f, 2'b01);
    chk("single_en_+2",  en_f, 2'b01);
    tick();
    chk("single_ack_1cyc", ack_f, 0);
    chk("single_en_held",  en_f, 2'b01);
    repeat (7) tick();
    pulse_done_f(2'b00, 1'b0, 2'b00);
    chk("single_en_off",  en_f, 0);
    chk("single_bus_off", req_f_bus, 0);
    chk("single_irq",     irq_f, 2'b01);
    chk("single_intr",    intr_f, 1);
    clr_f = 2'b01;
    tick();
    clr_f = 2'b00;
    chk("single_clr_intr", intr_f, 0);
    chk("single_clr_irq",  irq_f, 0);

    // Fixed priority: ch1 before ch0, with bus release between them
    req_f = 2'b11;
    wait_ack(0, ack);
    chk("fix_first_ch1", ack, 4'b0010);
    chk("fix_act1", act_f, 1);
    tick();
    pulse_done_f(2'b01, 1'b0, 2'b00);
    chk("fix_irq_10", irq_f, 2'b10);
    tick();
    chk("fix_release", req_f_bus, 0);
    tick();
    chk("fix_rereq_+2", req_f_bus, 1);
    wait_ack(0, ack);
    chk("fix_second_ch0", ack, 4'b0001);
    tick();
    pulse_done_f(2'b00, 1'b0, 2'b00);
    chk("fix_irq_11", irq_f, 2'b11);
    clr_f = 2'b11;
    tick();
    clr_f = 2'b00;

    // Grant withheld 5 cycles
    grant_f = 0; req_f = 2'b01;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("nogrant_bus_req", req_f_bus, 1);
      chk("nogrant_no_ack",  ack_f, 0);
      tick();
    end
    grant_f = 1;
    tick();
    chk("grant_ack", ack_f, 2'b01);
    tick();
    // Grant lost 3 cycles mid-XFER
    grant_f = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_on",     hold_f, 1);
      chk("hold_en",     en_f, 2'b01);
      chk("hold_busreq", req_f_bus, 1);
      tick();
    end
    grant_f = 1;
    #1;
    chk("hold_off", hold_f, 0);
    chk("hold_en_after", en_f, 2'b01);
    tick();
    pulse_done_f(2'b00, 1'b0, 2'b00);
    clr_f = 2'b11;
    tick();
    clr_f = 2'b00;

    // Request dropped before grant
    grant_f = 0; req_f = 2'b10;
    tick();
    chk("drop_bus_req", req_f_bus, 1);
    chk("drop_act", act_f, 1);
    req_f = 2'b00;
    tick();
    chk("drop_bus_off", req_f_bus, 0);
    grant_f = 1;
    for (int i = 0; i < 3; i++) begin
      chk("drop_no_ack", ack_f, 0);
      tick();
    end

    // Error and done together on ch1, clear in the same cycle as the set
    req_f = 2'b10;
    wait_ack(0, ack);
    chk("err_ack_ch1", ack, 4'b0010);
    req_f = 2'b00;
    tick();
    pulse_done_f(2'b00, 1'b1, 2'b10);
    chk("err_src", errs_f, 2'b10);
    chk("err_irq", irq_f, 2'b10);
    chk("err_en_off", en_f, 0);
    clr_f = 2'b10;
    tick();
    clr_f = 2'b00;
    chk("err_clr_err", errs_f, 0);
    chk("err_clr_irq", irq_f, 0);

    // Round-robin, all four requesting, order 0,1,2,3,0
    req_r = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(1, ack);
      chk("rr_order", ack, 4'b0001 << order[k]);
      chk("rr_ptr", u_rr.rr_ptr, order[k]);
      tick();
      done_r = 1;
      tick();
      done_r = 0;
    end
    chk("rr_irq_all", irq_r, 4'b1111);
    wait_ack(1, ack);
    chk("rr_next_ch1", ack, 4'b0010);
    tick();

    // Reset mid-XFER on the round-robin instance
    rst_r = 1;
    tick();
    chk("rstx_en",    en_r, 0);
    chk("rstx_bus",   req_r_bus, 0);
    chk("rstx_ack",   ack_r, 0);
    chk("rstx_flags", {irq_r, errs_r, intr_r}, 0);
    chk("rstx_act",   act_r, 0);
    chk("rstx_hold",  hold_r, 0);
    rst_r = 0;
    tick();
    chk("rstx_bus_+1", req_r_bus, 1);
    tick();
    chk("rstx_ack_ch0", ack_r, 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
